nonce_sweep_ctrl: RTL

//  Nonce-search sequencer between the Avalon register wrapper and sha256_module.

---
 rtl/miner_pkg.sv | 19 +
 rtl/hash_lt_target.sv | 10 +
 rtl/nonce_sweep_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared sweep state encoding, bus widths and nonce insertion helper.
package miner_pkg;
    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;
    localparam int WORD_W  = 32;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} sweep_state_t;

    // Word 0 is the most significant word of the block, matching SHA-256 message order.
    function automatic logic [BLOCK_W-1:0] insert_nonce(input logic [BLOCK_W-1:0] blk,
                                                        input logic [NONCE_W-1:0] nonce,
                                                        input int idx);
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[BLOCK_W-1-idx*WORD_W -: WORD_W] = nonce;
        return r;
    endfunction
endpackage

// File: rtl/hash_lt_target.sv
// hash_lt_target: unsigned digest-below-target compare, purely combinational.
module hash_lt_target
    import miner_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              lt
);
    assign lt = hash < target;
endmodule

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: sweeps a nonce range through the SHA-256 core until digest < target.
// Define SWEEP_STATS_EN to add the saturating tried_count statistics port.
module nonce_sweep_ctrl
    import miner_pkg::*;
#(
    parameter int NONCE_WORD = 3
`ifdef SWEEP_STATS_EN
    , parameter int CNT_W = 32
`endif
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               abort,
    input  logic [BLOCK_W-1:0] block_tmpl,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target,
    output logic               core_start,
    output logic               core_reset,
    output logic [BLOCK_W-1:0] core_block,
    input  logic [HASH_W-1:0]  core_hash,
    input  logic               core_done,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash
`ifdef SWEEP_STATS_EN
    , output logic [CNT_W-1:0] tried_count
`endif
);
    sweep_state_t       state, state_nxt;
    logic [BLOCK_W-1:0] tmpl_r;
    logic [NONCE_W-1:0] end_r, cur_nonce, nonce_nxt;
    logic [HASH_W-1:0]  target_r, hash_r;
    logic               first_wait, lt, launch, capture;

    hash_lt_target u_lt (.hash(hash_r), .target(target_r), .lt(lt));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: state_nxt = go ? S_ISSUE : state;
            S_ISSUE:        state_nxt = S_WAIT;
            S_WAIT:         state_nxt = (core_done && !first_wait) ? S_CHECK : S_WAIT;
            S_CHECK:        state_nxt = (lt || cur_nonce == end_r) ? S_DONE : S_ISSUE;
            default:        state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    assign busy       = state inside {S_ISSUE, S_WAIT, S_CHECK};
    assign core_start = state == S_ISSUE;
    assign launch     = go && !busy && !abort;
    assign capture    = state == S_WAIT && state_nxt == S_CHECK;
    assign nonce_nxt  = launch ? nonce_start : cur_nonce + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tmpl_r      <= '0;
            end_r       <= '0;
            target_r    <= '0;
            cur_nonce   <= '0;
            hash_r      <= '0;
            first_wait  <= 1'b0;
            core_reset  <= 1'b0;
            core_block  <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
`ifdef SWEEP_STATS_EN
            tried_count <= '0;
`endif
        end else begin
            state      <= state_nxt;
            core_reset <= abort && busy;
            // A done level left over from the previous hash is masked for one WAIT cycle.
            first_wait <= state == S_ISSUE;
            if (launch) begin
                tmpl_r      <= block_tmpl;
                end_r       <= nonce_end;
                target_r    <= target;
                found       <= 1'b0;
                exhausted   <= 1'b0;
                found_nonce <= '0;
                found_hash  <= '0;
            end
            if (launch || (state == S_CHECK && state_nxt == S_ISSUE))
                cur_nonce <= nonce_nxt;
            if (state_nxt == S_ISSUE)
                core_block <= insert_nonce(launch ? block_tmpl : tmpl_r, nonce_nxt, NONCE_WORD);
            if (capture)
                hash_r <= core_hash;
            if (state == S_CHECK && !abort) begin
                found       <= found | lt;
                exhausted   <= exhausted | (!lt && cur_nonce == end_r);
                found_nonce <= lt ? cur_nonce : found_nonce;
                found_hash  <= lt ? hash_r : found_hash;
            end
`ifdef SWEEP_STATS_EN
            if (launch)
                tried_count <= '0;
            else if (capture && !(&tried_count))
                tried_count <= tried_count + 1'b1;
`endif
        end
    end
endmodule
